// File: rtl/pin_tx.sv
// Serial pin transmitter: byte FIFO feeding a start/8N/stop framer.
// Every start bit is preceded by GAP_BITS*BAUD idle-high cycles.
module pin_tx #(
  parameter int BAUD       = 3,
  parameter int GAP_BITS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dato,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       data_sent
);

  localparam int GAP_LEN = GAP_BITS * BAUD;
  localparam int BAUD_W  = $clog2(BAUD);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(GAP_LEN);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              data_sent_q, data_sent_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [2:0]        nxt_bit;

  logic [7:0] fifo_mem [FIFO_DEPTH];

  // Storage is not reset: an empty FIFO is defined purely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dato;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    data_sent_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop         = 1'b0;
    push        = load && ready_q;
    nxt_bit     = idx_q[2:0] + 3'd1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (gap_q != GAP_FULL) begin
          gap_d = gap_q + GAP_W'(1);
        end
        // Launch on the edge that completes the L-th idle cycle.
        if (gap_q >= GAP_LAST && count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (idx_q == 4'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = {1'b0, nxt_bit};
            tx_d  = shift_q[nxt_bit];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d      = '0;
          gap_d       = '0;
          data_sent_d = 1'b1;
          state_d     = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ready_d = (count_d != DEPTH_C);
    // data_sent_d keeps busy high through the pulse cycle so it drops one cycle later.
    busy_d  = (state_d != IDLE) || (count_d != '0) || data_sent_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      data_sent_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      data_sent_q <= data_sent_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign ready     = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign data_sent = data_sent_q;

endmodule
